uart_frame_checker: RTL
=======================

// Module: uart_frame_checker
// PURPOSE
//  Parametrised UART RX frame checker. Successor to the single stop-bit checker.
//  Sits after the RX bit sampler and consumes one mid-bit sample per bit_valid strobe.
//  Assembles LSB-first data, checks optional even/odd parity and 1 or 2 stop bits,
//  reports per-frame error flags and keeps a saturating error-frame count.
// PARAMETERS
//  WIDTH        8  data bits per frame, legal 5..9
//  PARITY_MODE  0  0 = none, 1 = even, 2 = odd
//  STOP_BITS    1  stop bits checked, legal 1 or 2
//  CNT_W        8  width of frame_err_cnt
// PORTS
//  clk            in   1      clock; all state updates on rising edge
//  rst            in   1      asynchronous, active-high reset
//  frame_start    in   1      1-cycle pulse: start bit confirmed by sampler
//  bit_valid      in   1      1-cycle pulse: RX_data holds a valid mid-bit sample
//  RX_data        in   1      sampled serial bit
//  clr_cnt        in   1      synchronous clear of frame_err_cnt
//  data_out       out  WIDTH  received data word, LSB = first data bit
//  frame_done     out  1      1-cycle pulse: frame complete, outputs valid
//  parity_err     out  1      parity mismatch on last completed frame
//  stop_bit_err   out  1      any stop bit sampled 0 on last completed frame
//  frame_err_cnt  out  CNT_W  count of completed frames with any error, saturating
//  busy           out  1      high while FSM not IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE, bit_cnt=0, parity acc=0, all outputs 0.
//  FSM states: IDLE, DATA, PARITY, STOP.
//   IDLE:   frame_start -> DATA; clear bit_cnt, acc, shift reg.
//   DATA:   per bit_valid, shift RX_data in at MSB, shift right (LSB-first), acc ^= RX_data,
//           bit_cnt++. On the WIDTH-th bit -> PARITY if PARITY_MODE!=0, else STOP.
//   PARITY: one bit_valid: perr = (acc ^ RX_data) for even, ~(acc ^ RX_data) for odd -> STOP.
//   STOP:   per bit_valid, serr |= ~RX_data. On the STOP_BITS-th stop bit -> IDLE, with
//           registered updates on that same edge:
//           data_out, parity_err(=perr), stop_bit_err(=serr) load; frame_done=1 one cycle.
//  Latency: frame_done high the cycle after the clock edge sampling the last stop bit.
//  data_out/parity_err/stop_bit_err hold until the next frame_done; never change mid-frame.
//  parity_err always 0 when PARITY_MODE=0.
//  frame_err_cnt: +1 on frame_done when parity_err|stop_bit_err; saturates at all-ones.
//  Boundary rules:
//   - frame_start while busy: abort current frame (no frame_done, flags/count unchanged),
//     restart in DATA.
//   - frame_start and bit_valid same cycle: frame_start wins, sample discarded.
//   - bit_valid in IDLE: ignored.
//   - clr_cnt same cycle as increment: clear wins, count = 0.
//   - rst mid-frame: immediate return to reset state, partial frame discarded.
//  bit_valid with no gap between consecutive strobes is legal (back-to-back every cycle).
// TESTING
//  1. WIDTH=8, none, 1 stop: bits 0x A5 then stop=1 -> frame_done, data_out=0xA5,
//     both errs 0, cnt=0.
//  2. Same, stop=0 -> stop_bit_err=1, cnt=1; next clean frame -> stop_bit_err=0, cnt=1.
//  3. PARITY_MODE=1, data 0x07 parity 1 -> no err; parity 0 -> parity_err=1, cnt+1.
//     Repeat PARITY_MODE=2 with inverted expectations.
//  4. STOP_BITS=2: stops 1,0 -> stop_bit_err=1; frame_done only after second stop bit.
//  5. frame_start after 4 data bits -> no frame_done, new frame 0x3C completes correctly;
//     rst asserted mid-frame -> all outputs 0, busy=0.
//  6. CNT_W=2: four error frames -> cnt=3 (saturated); clr_cnt with error frame_done -> 0.

Source files
------------

// File: rtl/uart_frame_checker.sv
// rtl/uart_frame_checker.sv - UART RX frame checker: data assembly, parity, stop bits, error count
module uart_frame_checker #(
    parameter int WIDTH       = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             bit_valid,
    input  logic             RX_data,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] data_out,
    output logic             frame_done,
    output logic             parity_err,
    output logic             stop_bit_err,
    output logic [CNT_W-1:0] frame_err_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // WIDTH is at most 9, so a 4-bit counter covers every data bit index.
    localparam logic [3:0] LAST_BIT  = 4'(WIDTH - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic       HAS_PAR   = (PARITY_MODE != 0);
    localparam logic       ODD_PAR   = (PARITY_MODE == 2);

    state_t           state_q;
    logic [3:0]       bit_cnt_q;
    logic             stop_cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic             acc_q;
    logic             perr_q;
    logic             serr_q;
    logic [WIDTH-1:0] data_out_q;
    logic             parity_err_q;
    logic             stop_err_q;
    logic             frame_done_q;
    logic [CNT_W-1:0] cnt_q;

    // Stop error including the stop bit currently on the line.
    logic             serr_d;
    // Parity check result for the parity bit currently on the line.
    logic             perr_d;

    // Combine the sampled bit with the running frame state.
    always_comb begin
        serr_d = serr_q | ~RX_data;
        perr_d = (acc_q ^ RX_data) ^ ODD_PAR;
    end

    // Frame FSM with registered result outputs and saturating error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            shift_q      <= '0;
            acc_q        <= 1'b0;
            perr_q       <= 1'b0;
            serr_q       <= 1'b0;
            data_out_q   <= '0;
            parity_err_q <= 1'b0;
            stop_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (clr_cnt) begin
                cnt_q <= '0;
            end
            if (frame_start) begin
                // Also aborts any frame in progress; a coincident sample is dropped.
                state_q    <= DATA;
                bit_cnt_q  <= '0;
                stop_cnt_q <= 1'b0;
                shift_q    <= '0;
                acc_q      <= 1'b0;
                perr_q     <= 1'b0;
                serr_q     <= 1'b0;
            end else if (bit_valid) begin
                case (state_q)
                    DATA: begin
                        shift_q   <= {RX_data, shift_q[WIDTH-1:1]};
                        acc_q     <= acc_q ^ RX_data;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= HAS_PAR ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        perr_q  <= perr_d;
                        state_q <= STOP;
                    end
                    STOP: begin
                        serr_q     <= serr_d;
                        stop_cnt_q <= stop_cnt_q + 1'b1;
                        if (stop_cnt_q == LAST_STOP) begin
                            state_q      <= IDLE;
                            data_out_q   <= shift_q;
                            parity_err_q <= perr_q;
                            stop_err_q   <= serr_d;
                            frame_done_q <= 1'b1;
                            if (!clr_cnt && (perr_q || serr_d) && (cnt_q != '1)) begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign data_out      = data_out_q;
    assign frame_done    = frame_done_q;
    assign parity_err    = parity_err_q;
    assign stop_bit_err  = stop_err_q;
    assign frame_err_cnt = cnt_q;
    assign busy          = (state_q != IDLE);

endmodule
